// File: rtl/ps2_snake_cmd_decoder_if.sv
// Byte-stream / command bundle between the PS/2 receiver, the snake command decoder and the game FSM.
interface ps2_snake_cmd_decoder_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic       game_tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic       pause_toggle;
  logic       restart;
  logic       cmd_drop;

  modport master (
    output key_code, key_valid, game_tick,
    input  dir, dir_changed, pause_toggle, restart, cmd_drop
  );

  modport slave (
    input  key_code, key_valid, game_tick,
    output dir, dir_changed, pause_toggle, restart, cmd_drop
  );
endinterface

// File: rtl/ps2_snake_cmd_decoder.sv
// Set-2 scancode to snake command decoder with E0/F0 prefix tracking and a 2-entry direction queue.
// Define SNAKE_CMD_WASD_EN to let W/A/S/D steer in addition to the arrow keys.
module ps2_snake_cmd_decoder #(
  parameter logic [1:0] INIT_DIR = 2'b00
) (
  input logic                    clk,
  input logic                    rst,
  ps2_snake_cmd_decoder_if.slave bus
);

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodeSpace = 8'h29;
  localparam logic [7:0] CodeEnter = 8'h5A;
  localparam logic [7:0] CodeUp    = 8'h75;
  localparam logic [7:0] CodeDown  = 8'h72;
  localparam logic [7:0] CodeLeft  = 8'h6B;
  localparam logic [7:0] CodeRight = 8'h74;

  localparam logic [1:0] DirRight = 2'b00;
  localparam logic [1:0] DirUp    = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirDown  = 2'b11;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       space_held_q, space_held_d;
  logic       enter_held_q, enter_held_d;
  logic       dir_changed_q, dir_changed_d;
  logic       pause_toggle_q, pause_toggle_d;
  logic       restart_q, restart_d;
  logic       cmd_drop_q, cmd_drop_d;

  logic       is_make, is_break, is_ext;
  logic       new_vld;
  logic [1:0] new_dir;
  logic [1:0] ref_dir;
  logic       push, pop;

  // Prefix FSM: classifies the current byte as make/break, plain/extended.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    if (bus.key_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.key_code == CodeExt)      state_d = StExt;
          else if (bus.key_code == CodeBrk) state_d = StBrk;
          else                              is_make = 1'b1;
        end
        StExt: begin
          if (bus.key_code == CodeBrk) begin
            state_d = StExtBrk;
          end else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          is_break = 1'b1;
          state_d  = StIdle;
        end
        StExtBrk: begin
          is_break = 1'b1;
          is_ext   = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Direction decode; breaks of direction keys never reach here.
  always_comb begin
    new_vld = 1'b0;
    new_dir = DirRight;
    if (is_make && is_ext) begin
      new_vld = 1'b1;
      case (bus.key_code)
        CodeUp:    new_dir = DirUp;
        CodeDown:  new_dir = DirDown;
        CodeLeft:  new_dir = DirLeft;
        CodeRight: new_dir = DirRight;
        default:   new_vld = 1'b0;
      endcase
    end
`ifdef SNAKE_CMD_WASD_EN
    if (is_make && !is_ext) begin
      new_vld = 1'b1;
      case (bus.key_code)
        8'h1D:   new_dir = DirUp;
        8'h1B:   new_dir = DirDown;
        8'h1C:   new_dir = DirLeft;
        8'h23:   new_dir = DirRight;
        default: new_vld = 1'b0;
      endcase
    end
`endif
  end

  // Reversal reference is the last direction the snake will have taken once the queue drains.
  assign ref_dir = (cnt_q == 2'd2) ? q1_q : (cnt_q == 2'd1) ? q0_q : dir_q;
  assign push    = new_vld && (new_dir != ref_dir) && (new_dir != (ref_dir ^ 2'b10));
  assign pop     = bus.game_tick && (cnt_q != 2'd0);

  always_comb begin
    space_held_d   = space_held_q;
    enter_held_d   = enter_held_q;
    pause_toggle_d = 1'b0;
    restart_d      = 1'b0;
    cmd_drop_d     = 1'b0;
    dir_changed_d  = 1'b0;
    dir_d          = dir_q;
    q0_d           = q0_q;
    q1_d           = q1_q;
    cnt_d          = cnt_q;

    if (!is_ext && bus.key_code == CodeSpace) begin
      if (is_make) begin
        pause_toggle_d = !space_held_q;
        space_held_d   = 1'b1;
      end else if (is_break) begin
        space_held_d = 1'b0;
      end
    end
    if (!is_ext && bus.key_code == CodeEnter) begin
      if (is_make) begin
        restart_d    = !enter_held_q;
        enter_held_d = 1'b1;
      end else if (is_break) begin
        enter_held_d = 1'b0;
      end
    end

    if (restart_d) begin
      // Restart overrides any tick or push in the same cycle.
      dir_d = INIT_DIR;
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        dir_d         = q0_q;
        dir_changed_d = 1'b1;
      end
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            q0_d  = new_dir;
            cnt_d = 2'd1;
          end
        end
        2'd1: begin
          if (pop && push)  q0_d = new_dir;
          else if (pop)     cnt_d = 2'd0;
          else if (push) begin
            q1_d  = new_dir;
            cnt_d = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            q0_d = q1_q;
            if (push) q1_d = new_dir;
            else      cnt_d = 2'd1;
          end else if (push) begin
            cmd_drop_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      dir_q          <= INIT_DIR;
      q0_q           <= 2'b00;
      q1_q           <= 2'b00;
      cnt_q          <= 2'd0;
      space_held_q   <= 1'b0;
      enter_held_q   <= 1'b0;
      dir_changed_q  <= 1'b0;
      pause_toggle_q <= 1'b0;
      restart_q      <= 1'b0;
      cmd_drop_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      q0_q           <= q0_d;
      q1_q           <= q1_d;
      cnt_q          <= cnt_d;
      space_held_q   <= space_held_d;
      enter_held_q   <= enter_held_d;
      dir_changed_q  <= dir_changed_d;
      pause_toggle_q <= pause_toggle_d;
      restart_q      <= restart_d;
      cmd_drop_q     <= cmd_drop_d;
    end
  end

  assign bus.dir          = dir_q;
  assign bus.dir_changed  = dir_changed_q;
  assign bus.pause_toggle = pause_toggle_q;
  assign bus.restart      = restart_q;
  assign bus.cmd_drop     = cmd_drop_q;

endmodule

// File: tb/tb_ps2_snake_cmd_decoder.sv
// Directed, table-driven bench for ps2_snake_cmd_decoder (INIT_DIR = RIGHT).
module tb_ps2_snake_cmd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_snake_cmd_decoder_if bus ();

  ps2_snake_cmd_decoder #(
    .INIT_DIR(2'b00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       kv;
    logic [7:0] code;
    logic       tick;
    logic [5:0] exp; // {dir, dir_changed, pause_toggle, restart, cmd_drop}
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef SNAKE_CMD_WASD_EN
  localparam logic [5:0] ExpWasdTick = 6'b01_1000;
`else
  localparam logic [5:0] ExpWasdTick = 6'b00_0000;
`endif

  task automatic add(input logic kv, input logic [7:0] code, input logic tick,
                     input logic [5:0] exp);
    vec_t v;
    v.kv = kv; v.code = code; v.tick = tick; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [5:0] exp);
    logic [5:0] act;
    act = {bus.dir, bus.dir_changed, bus.pause_toggle, bus.restart, bus.cmd_drop};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: {dir,dc,pt,rs,drop} got %b_%b%b%b%b want %b_%b%b%b%b", name, idx,
               act[5:4], act[3], act[2], act[1], act[0], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run(input string name, input int idx, input logic kv, input logic [7:0] code,
                     input logic tick, input logic [5:0] exp);
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.game_tick = tick;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.game_tick = 1'b0;
    check(name, idx, exp);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.game_tick = 1'b0;

    // Reset / basic UP command
    add(0, 8'h00, 0, 6'b00_0000);
    add(1, 8'hE0, 0, 6'b00_0000);
    add(1, 8'h75, 0, 6'b00_0000);
    add(0, 8'h00, 1, 6'b01_1000);
    add(0, 8'h00, 0, 6'b01_0000);
    // Reversal from UP (DOWN rejected), then RIGHT accepted, then LEFT rejected
    add(1, 8'hE0, 0, 6'b01_0000);
    add(1, 8'h72, 0, 6'b01_0000);
    add(0, 8'h00, 1, 6'b01_0000);
    add(1, 8'hE0, 0, 6'b01_0000);
    add(1, 8'h74, 0, 6'b01_0000);
    add(0, 8'h00, 1, 6'b00_1000);
    add(1, 8'hE0, 0, 6'b00_0000);
    add(1, 8'h6B, 0, 6'b00_0000);
    add(0, 8'h00, 1, 6'b00_0000);
    // Queue fill and overflow drop, then drain
    add(1, 8'hE0, 0, 6'b00_0000);
    add(1, 8'h75, 0, 6'b00_0000);
    add(1, 8'hE0, 0, 6'b00_0000);
    add(1, 8'h6B, 0, 6'b00_0000);
    add(1, 8'hE0, 0, 6'b00_0000);
    add(1, 8'h72, 0, 6'b00_0001);
    add(0, 8'h00, 1, 6'b01_1000);
    add(0, 8'h00, 1, 6'b10_1000);
    add(0, 8'h00, 1, 6'b10_0000);
    // Space typematic: pulses on first make and after break
    add(1, 8'h29, 0, 6'b10_0100);
    add(1, 8'h29, 0, 6'b10_0000);
    add(1, 8'h29, 0, 6'b10_0000);
    add(1, 8'hF0, 0, 6'b10_0000);
    add(1, 8'h29, 0, 6'b10_0000);
    add(1, 8'h29, 0, 6'b10_0100);
    add(0, 8'h00, 0, 6'b10_0000);
    // Restart flushes queued UP and resets dir
    add(1, 8'hE0, 0, 6'b10_0000);
    add(1, 8'h75, 0, 6'b10_0000);
    add(1, 8'h5A, 0, 6'b00_0010);
    add(0, 8'h00, 1, 6'b00_0000);
    add(1, 8'h5A, 0, 6'b00_0000);
    add(1, 8'hF0, 0, 6'b00_0000);
    add(1, 8'h5A, 0, 6'b00_0000);
    // Extended break is not a command; WASD depends on build
    add(1, 8'hE0, 0, 6'b00_0000);
    add(1, 8'hF0, 0, 6'b00_0000);
    add(1, 8'h75, 0, 6'b00_0000);
    add(0, 8'h00, 1, 6'b00_0000);
    add(1, 8'h1D, 0, 6'b00_0000);
    add(0, 8'h00, 1, ExpWasdTick);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 6'b00_0000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run("vec", i, vecs[i].kv, vecs[i].code, vecs[i].tick, vecs[i].exp);

    // Reset after an E0 prefix: next 75 is unprefixed and ignored
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("midrst", 0, 1, 8'hE0, 0, 6'b00_0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst", 1, 6'b00_0000);
    run("midrst", 2, 1, 8'h75, 0, 6'b00_0000);
    run("midrst", 3, 0, 8'h00, 1, 6'b00_0000);

    // Push into empty queue with coincident tick is not popped
    run("emptytick", 0, 1, 8'hE0, 0, 6'b00_0000);
    run("emptytick", 1, 1, 8'h75, 1, 6'b00_0000);
    run("emptytick", 2, 0, 8'h00, 1, 6'b01_1000);

    // Full queue + tick + push: accepted, no drop
    run("fulltick", 0, 1, 8'hE0, 0, 6'b01_0000);
    run("fulltick", 1, 1, 8'h74, 0, 6'b01_0000);
    run("fulltick", 2, 1, 8'hE0, 0, 6'b01_0000);
    run("fulltick", 3, 1, 8'h72, 0, 6'b01_0000);
    run("fulltick", 4, 1, 8'hE0, 0, 6'b01_0000);
    run("fulltick", 5, 1, 8'h6B, 1, 6'b00_1000);
    run("fulltick", 6, 0, 8'h00, 1, 6'b11_1000);
    run("fulltick", 7, 0, 8'h00, 1, 6'b10_1000);
    run("fulltick", 8, 0, 8'h00, 1, 6'b10_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
